// File: rtl/alu_result_buffer_if.sv
// ALU result buffer handshake bundle.
// Upstream capture side plus downstream write-back side.
interface alu_result_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_result;
   logic                  in_zero;
   logic                  in_carry;
   logic                  in_overflow;
   logic [2:0]            in_aluop;
   logic [4:0]            in_rd;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_result;
   logic                  out_zero;
   logic                  out_carry;
   logic                  out_overflow;
   logic [4:0]            out_rd;
   logic                  out_wen;
   logic                  out_illegal;

   // ALU producer and write-back consumer
   modport master (
      output in_valid, in_result, in_zero, in_carry,
      output in_overflow, in_aluop, in_rd,
      input  in_ready,
      input  out_valid, out_result, out_zero, out_carry,
      input  out_overflow, out_rd, out_wen, out_illegal,
      output out_ready
   );

   // the buffer itself
   modport slave (
      input  in_valid, in_result, in_zero, in_carry,
      input  in_overflow, in_aluop, in_rd,
      output in_ready,
      output out_valid, out_result, out_zero, out_carry,
      output out_overflow, out_rd, out_wen, out_illegal,
      input  out_ready
   );
endinterface

// File: rtl/alu_result_buffer.sv
// 2-entry skid FIFO between the ALU and write-back.
// Masks flags per op, flags illegal ops, keeps debug state.
module alu_result_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_result_buffer_if.slave   bus,
   input  logic                 sticky_clr,
   output logic                 sticky_ovf,
   output logic [CNT_WIDTH-1:0] op_count
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic                  zero;
      logic                  carry;
      logic                  overflow;
      logic                  illegal;
      logic [4:0]            rd;
   } entry_t;

   entry_t     mem [2];
   entry_t     cap;
   entry_t     head_e;
   logic       head;
   logic       tail;
   logic [1:0] count;
   logic       push;
   logic       pop;
   logic       legal;
   logic       arith;

   assign bus.in_ready  = !rst && (count != 2'd2);
   assign bus.out_valid = (count != 2'd0);
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   // decode the op and build the masked entry to capture
   always_comb begin
      legal = 1'b0;
      arith = 1'b0;
      unique case (bus.in_aluop)
         3'b000, 3'b001,
         3'b111:         legal = 1'b1;
         3'b010, 3'b110: begin
            legal = 1'b1;
            arith = 1'b1;
         end
         default:        legal = 1'b0;
      endcase
      cap          = '0;
      cap.rd       = bus.in_rd;
      cap.illegal  = !legal;
      if (legal) begin
         cap.result   = bus.in_result;
         cap.zero     = bus.in_zero;
         cap.carry    = arith && bus.in_carry;
         cap.overflow = arith && bus.in_overflow;
      end
   end

   // storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         tail   <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[tail] <= cap;
            tail      <= ~tail;
         end
         if (pop) head <= ~head;
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // sticky overflow: a set beats a same-edge clear
   always_ff @(posedge clk) begin
      if (rst)
         sticky_ovf <= 1'b0;
      else if (push && cap.overflow)
         sticky_ovf <= 1'b1;
      else if (sticky_clr)
         sticky_ovf <= 1'b0;
   end

   // retired-op counter, wraps naturally
   always_ff @(posedge clk) begin
      if (rst)
         op_count <= '0;
      else if (pop)
         op_count <= op_count + 1'b1;
   end

   // head view, zeroed whenever the buffer is empty
   always_comb begin
      head_e = '0;
      if (bus.out_valid) head_e = mem[head];
   end

   assign bus.out_result   = head_e.result;
   assign bus.out_zero     = head_e.zero;
   assign bus.out_carry    = head_e.carry;
   assign bus.out_overflow = head_e.overflow;
   assign bus.out_rd       = head_e.rd;
   assign bus.out_illegal  = head_e.illegal;
   assign bus.out_wen      = bus.out_valid
                           && (head_e.rd != 5'd0)
                           && !head_e.illegal;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer.
// Counter width reduced to 4 to reach the wrap quickly.
module tb_alu_result_buffer;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          sticky_clr;
   logic          sticky_ovf;
   logic [CW-1:0] op_count;

   int n_chk  = 0;
   int n_pass = 0;

   alu_result_buffer_if #(.DATA_WIDTH(DW)) bus ();

   alu_result_buffer #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .sticky_clr(sticky_clr),
      .sticky_ovf(sticky_ovf),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h",
                    tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op,
                        input logic [31:0] res,
                        input logic z, input logic c,
                        input logic v, input logic [4:0] rd);
      bus.in_valid    = 1'b1;
      bus.in_aluop    = op;
      bus.in_result   = res;
      bus.in_zero     = z;
      bus.in_carry    = c;
      bus.in_overflow = v;
      bus.in_rd       = rd;
   endtask

   initial begin
      rst           = 1'b1;
      sticky_clr    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_aluop  = 3'b000;
      bus.in_result = '0;
      bus.in_zero   = 1'b0;
      bus.in_carry  = 1'b0;
      bus.in_overflow = 1'b0;
      bus.in_rd     = 5'd0;
      bus.out_ready = 1'b0;

      // reset
      step();
      step();
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_op_count", {28'd0, op_count}, 32'd0);
      check("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
      check("rst_out_result", bus.out_result, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // single ADD, one-cycle latency
      bus.out_ready = 1'b1;
      drive(3'b010, 32'h5, 1'b0, 1'b1, 1'b0, 5'd3);
      step();
      bus.in_valid = 1'b0;
      check("add_valid", {31'd0, bus.out_valid}, 32'd1);
      check("add_result", bus.out_result, 32'd5);
      check("add_carry", {31'd0, bus.out_carry}, 32'd1);
      check("add_wen", {31'd0, bus.out_wen}, 32'd1);
      check("add_rd", {27'd0, bus.out_rd}, 32'd3);
      step();
      check("add_drained", {31'd0, bus.out_valid}, 32'd0);
      check("add_count", {28'd0, op_count}, 32'd1);

      // fill while stalled, third must wait
      bus.out_ready = 1'b0;
      drive(3'b010, 32'h11, 1'b0, 1'b0, 1'b0, 5'd1);
      step();
      drive(3'b010, 32'h22, 1'b0, 1'b0, 1'b0, 5'd2);
      step();
      drive(3'b010, 32'h33, 1'b0, 1'b0, 1'b0, 5'd3);
      check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      check("stall_head", bus.out_result, 32'h11);
      bus.out_ready = 1'b1;
      #1;
      check("full_pop_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      check("order_b", bus.out_result, 32'h22);
      check("ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      check("order_c", bus.out_result, 32'h33);
      check("order_c_rd", {27'd0, bus.out_rd}, 32'd3);
      step();
      check("fill_drained", {31'd0, bus.out_valid}, 32'd0);
      check("fill_count", {28'd0, op_count}, 32'd4);

      // flag masking and sticky overflow
      drive(3'b000, 32'h0, 1'b1, 1'b1, 1'b1, 5'd4);
      step();
      check("and_carry", {31'd0, bus.out_carry}, 32'd0);
      check("and_ovf", {31'd0, bus.out_overflow}, 32'd0);
      check("and_zero", {31'd0, bus.out_zero}, 32'd1);
      check("and_sticky", {31'd0, sticky_ovf}, 32'd0);
      drive(3'b110, 32'h7, 1'b0, 1'b0, 1'b1, 5'd5);
      step();
      check("sub_ovf", {31'd0, bus.out_overflow}, 32'd1);
      check("sub_sticky", {31'd0, sticky_ovf}, 32'd1);
      drive(3'b110, 32'h9, 1'b0, 1'b1, 1'b1, 5'd6);
      sticky_clr = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("set_wins", {31'd0, sticky_ovf}, 32'd1);
      check("sub2_carry", {31'd0, bus.out_carry}, 32'd1);
      step();
      sticky_clr = 1'b0;
      check("sticky_clr", {31'd0, sticky_ovf}, 32'd0);
      check("mask_count", {28'd0, op_count}, 32'd7);

      // illegal op and rd=0
      bus.out_ready = 1'b0;
      drive(3'b100, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 5'd7);
      step();
      check("ill_flag", {31'd0, bus.out_illegal}, 32'd1);
      check("ill_result", bus.out_result, 32'd0);
      check("ill_wen", {31'd0, bus.out_wen}, 32'd0);
      check("ill_ovf", {31'd0, bus.out_overflow}, 32'd0);
      check("ill_rd", {27'd0, bus.out_rd}, 32'd7);
      check("ill_sticky", {31'd0, sticky_ovf}, 32'd0);
      bus.out_ready = 1'b1;
      drive(3'b111, 32'h1, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      bus.in_valid = 1'b0;
      check("slt_result", bus.out_result, 32'd1);
      check("slt_illegal", {31'd0, bus.out_illegal}, 32'd0);
      check("slt_rd0_wen", {31'd0, bus.out_wen}, 32'd0);
      step();
      check("ill_count", {28'd0, op_count}, 32'd9);

      // reset while full
      bus.out_ready = 1'b0;
      drive(3'b001, 32'hA, 1'b0, 1'b0, 1'b0, 5'd8);
      step();
      drive(3'b001, 32'hB, 1'b0, 1'b0, 1'b0, 5'd9);
      step();
      check("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
      drive(3'b010, 32'hC, 1'b0, 1'b0, 1'b1, 5'd10);
      bus.out_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_hi_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_count", {28'd0, op_count}, 32'd0);
      check("mid_rst_result", bus.out_result, 32'd0);
      check("mid_rst_sticky", {31'd0, sticky_ovf}, 32'd0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      check("no_stale", {31'd0, bus.out_valid}, 32'd0);
      check("no_stale_count", {28'd0, op_count}, 32'd0);

      // counter wrap with streaming traffic
      drive(3'b010, 32'h1, 1'b0, 1'b0, 1'b0, 5'd1);
      step();
      for (int i = 0; i < 15; i++) begin
         bus.in_result = 32'(i + 2);
         step();
      end
      check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stream_head", bus.out_result, 32'd16);
      check("pre_wrap", {28'd0, op_count}, 32'd15);
      bus.in_valid = 1'b0;
      step();
      check("wrap", {28'd0, op_count}, 32'd0);
      check("wrap_empty", {31'd0, bus.out_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered stage directly downstream of the 32-bit ALU: captures the ALU's Result/Zero/CarryOut/Overflow together with the ALUop and destination register index, and holds them in a 2-entry skid FIFO under a valid/ready handshake. It feeds the write-back path, masking flags that are meaningless for the issued op and flagging illegal opcodes. It also keeps a sticky overflow indicator and a retired-op counter for debug.

## Interface
- DATA_WIDTH, 32, width of result datapath
- CNT_WIDTH, 16, width of retired-op counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high (already decided)
- in_valid  in  1  upstream (ALU side) entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_result  in  DATA_WIDTH  ALU Result
- in_zero / in_carry / in_overflow  in  1 each  ALU Zero / CarryOut / Overflow
- in_aluop  in  3  ALUop that produced the result
- in_rd  in  5  destination register index
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- out_result  out  DATA_WIDTH  head result (0 if illegal)
- out_zero / out_carry / out_overflow  out  1 each  head flags after masking
- out_rd  out  5  head destination index
- out_wen  out  1  head writes register file: out_valid && out_rd!=0 && !out_illegal
- out_illegal  out  1  head ALUop not in {000,001,010,110,111}
- sticky_ovf  out  1  set by any accepted masked overflow
- sticky_clr  in  1  clears sticky_ovf
- op_count  out  CNT_WIDTH  number of entries popped since reset

## Operation
- Storage: 2 entries, head/tail pointers (1 bit each) plus occupancy count 0..2.
- in_ready = !rst && count!=2. Push when in_valid && in_ready; pop when out_valid && out_ready.
- out_valid = count!=0; out_* driven from head entry register (no combinational in->out path).
- Full (count=2): no push even if pop occurs same cycle; in_ready stays 0 that cycle.
- Empty: no pass-through; out_ready ignored.
- Push and pop same cycle with count=1: count stays 1, head advances, new entry at tail.
- Flag masking at capture: carry and overflow stored only for ALUop 010 (ADD) and 110 (SUB), else stored 0. Zero stored as supplied for all legal ops.
- Illegal ALUop (011,100,101): entry accepted, stored result=0, zero=0, carry=0, overflow=0, illegal=1.
- sticky_ovf: set at edge of a push whose masked overflow=1; cleared by sticky_clr; set and clear same edge -> set wins.
- op_count: +1 per pop, wraps 2^CNT_WIDTH-1 -> 0.
- Data held in entries is not modified while stalled (out_valid && !out_ready).

## Timing
- Reset (rst sampled high at edge): count=0, pointers=0, sticky_ovf=0, op_count=0; all out_* = 0; in_ready=0 while rst high, 1 first cycle after.
- Reset mid-operation discards all entries in the same edge; in-flight handshake that cycle is ignored.
- Latency: entry pushed at edge N appears on out_* with out_valid=1 in cycle after edge N (1 cycle) if buffer was empty.
- Throughput: 1 entry/cycle sustained when out_ready held high.
- Outputs change only on clk rising edges, except in_ready and out_wen which are functions of registered state (and rst for in_ready).

## Test plan
- Reset then push ADD, A result 0x0000_0005, carry=1, ovf=0, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=5, out_carry=1, out_wen=1; following cycle out_valid=0, op_count=1.
- out_ready=0, push 3 entries back-to-back -> first two accepted, in_ready=0 on third cycle; raise out_ready -> entries emerge in order, third accepted the cycle after first pop.
- Push AND with in_carry=1, in_overflow=1 -> out_carry=0, out_overflow=0, sticky_ovf stays 0; push SUB with in_overflow=1 -> sticky_ovf=1; assert sticky_clr same cycle as another overflowing SUB push -> sticky_ovf remains 1.
- Push ALUop=100, result 0xDEAD_BEEF, rd=7 -> out_illegal=1, out_result=0, out_wen=0; push SLT result 1 with rd=0 -> out_wen=0.
- Fill buffer (count=2), assert rst one cycle -> out_valid=0, op_count=0, in_ready=0 during rst, 1 after; no stale entries appear.
- Preload op_count near wrap via 65535 pops (or CNT_WIDTH=4, 15 pops) -> one more pop gives op_count=0.
